// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: FSM states, ALU op codes,
// data-processing cmd codes, condition codes and the "no shift" code.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        FETCH       = 4'd1,
        DECODE      = 4'd2,
        EXEC_R      = 4'd3,
        EXEC_I      = 4'd4,
        ALU_WB      = 4'd5,
        MEM_ADR     = 4'd6,
        MEM_RD      = 4'd7,
        MEM_WB      = 4'd8,
        MEM_WR      = 4'd9,
        BRANCH      = 4'd10,
        BRANCH_LINK = 4'd11
    } state_t;

    localparam logic [2:0] ALUOP_ADD = 3'b000;
    localparam logic [2:0] ALUOP_SUB = 3'b001;
    localparam logic [2:0] ALUOP_AND = 3'b010;
    localparam logic [2:0] ALUOP_ORR = 3'b011;
    localparam logic [2:0] ALUOP_MOV = 3'b100;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [2:0] SHIFT_NONE_DEF = 3'b111;

    typedef struct packed {
        logic       valid;
        logic [2:0] aluop;
    } alu_decode_t;

    // Unsupported cmd values come back with valid=0 so the FSM can squash them.
    function automatic alu_decode_t decode_cmd(input logic [3:0] cmd);
        alu_decode_t d;
        d.valid = 1'b1;
        d.aluop = ALUOP_ADD;
        case (cmd)
            CMD_AND: d.aluop = ALUOP_AND;
            CMD_SUB: d.aluop = ALUOP_SUB;
            CMD_ADD: d.aluop = ALUOP_ADD;
            CMD_CMP: d.aluop = ALUOP_SUB;
            CMD_ORR: d.aluop = ALUOP_ORR;
            CMD_MOV: d.aluop = ALUOP_MOV;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Bundle between the controller and the multicycle datapath: IR/flags in,
// every datapath control plus debug state and retired count out.
interface multicycle_controller_if #(
    parameter int INSTR_W = 32,
    parameter int ALUOP_W = 3,
    parameter int SHIFT_W = 3,
    parameter int CNT_W   = 16
);
    logic [INSTR_W-1:0] INSTRUCTION;
    logic [3:0]         FLAGS;
    logic               A3Src, AdrSrc, FlagUpdate, IRWrite;
    logic               MemWrite, PCWrite, RegWrite, WD3Src;
    logic [1:0]         ALUSrcA, ALUSrcB, ResultSrc, RegSrc;
    logic [ALUOP_W-1:0] ALUop;
    logic [SHIFT_W-1:0] ShiftType;
    logic [3:0]         state_out;
    logic [CNT_W-1:0]   retired;

    modport master (
        input  INSTRUCTION, FLAGS,
        output A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src,
        output ALUSrcA, ALUSrcB, ResultSrc, RegSrc, ALUop, ShiftType, state_out, retired
    );

    modport slave (
        output INSTRUCTION, FLAGS,
        input  A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src,
        input  ALUSrcA, ALUSrcB, ResultSrc, RegSrc, ALUop, ShiftType, state_out, retired
    );
endinterface

// File: rtl/multicycle_controller_condition_unit.sv
// ARM-style condition evaluation: cond field against {N,Z,C,V}.
module condition_unit
    import multicycle_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_pass
);
    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = !z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = !c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = !n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = !v;
            COND_HI: cond_pass = c && !z;
            COND_LS: cond_pass = !c || z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = !z && (n == v);
            COND_LE: cond_pass = z || (n != v);
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle datapath with conditional execution and
// a retired-instruction counter. Define BRANCH_LINK_EN to enable the BL state.
module multicycle_controller
    import multicycle_ctrl_pkg::*;
#(
    parameter int                 INSTR_W    = 32,
    parameter int                 ALUOP_W    = 3,
    parameter int                 SHIFT_W    = 3,
    parameter logic [SHIFT_W-1:0] SHIFT_NONE = SHIFT_W'(SHIFT_NONE_DEF),
    parameter int                 CNT_W      = 16
) (
    input logic                    clock,
    input logic                    reset,
    multicycle_controller_if.master bus
);
    state_t           state_reg;
    logic [CNT_W-1:0] retired_reg;
    logic             cond_pass;
    alu_decode_t      cmd_dec;
    logic [3:0]       cmd;
    logic [1:0]       op;
    logic             imm_bit, s_bit, link_bit, is_cmp;
    logic             unused_instr;

    assign op       = bus.INSTRUCTION[27:26];
    assign imm_bit  = bus.INSTRUCTION[25];
    assign cmd      = bus.INSTRUCTION[24:21];
    assign link_bit = bus.INSTRUCTION[24];
    assign s_bit    = bus.INSTRUCTION[20];
    assign is_cmp   = (cmd == CMD_CMP);
    assign cmd_dec  = decode_cmd(cmd);
    assign unused_instr = ^{bus.INSTRUCTION[19:7], bus.INSTRUCTION[4:0], link_bit};

    condition_unit u_cond (
        .cond      (bus.INSTRUCTION[31:28]),
        .flags     (bus.FLAGS),
        .cond_pass (cond_pass)
    );

    // The counter steps only on transitions out of an instruction's final state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            retired_reg <= '0;
        end else begin
            case (state_reg)
                IDLE:   state_reg <= FETCH;
                FETCH:  state_reg <= DECODE;
                DECODE: begin
                    if (!cond_pass) begin
                        state_reg <= FETCH;
                    end else begin
                        case (op)
                            OP_DP:   state_reg <= imm_bit ? EXEC_I : EXEC_R;
                            OP_MEM:  state_reg <= MEM_ADR;
`ifdef BRANCH_LINK_EN
                            OP_BR:   state_reg <= link_bit ? BRANCH_LINK : BRANCH;
`else
                            OP_BR:   state_reg <= BRANCH;
`endif
                            default: state_reg <= FETCH;
                        endcase
                    end
                end
                EXEC_R, EXEC_I: begin
                    if (!cmd_dec.valid) begin
                        state_reg <= FETCH;
                    end else if (is_cmp) begin
                        state_reg   <= FETCH;
                        retired_reg <= retired_reg + CNT_W'(1);
                    end else begin
                        state_reg <= ALU_WB;
                    end
                end
                MEM_ADR: state_reg <= s_bit ? MEM_RD : MEM_WR;
                MEM_RD:  state_reg <= MEM_WB;
                ALU_WB, MEM_WB, MEM_WR, BRANCH, BRANCH_LINK: begin
                    state_reg   <= FETCH;
                    retired_reg <= retired_reg + CNT_W'(1);
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.A3Src      = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.FlagUpdate = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.WD3Src     = 1'b0;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ResultSrc  = 2'b00;
        bus.RegSrc     = 2'b00;
        bus.ALUop      = '0;
        bus.ShiftType  = SHIFT_NONE;
        case (state_reg)
            FETCH: begin
                bus.IRWrite   = 1'b1;
                bus.PCWrite   = 1'b1;
                bus.ALUSrcB   = 2'b11;
                bus.ResultSrc = 2'b10;
                bus.RegSrc    = 2'b10;
            end
            DECODE: bus.RegSrc = 2'b01;
            EXEC_R, EXEC_I: begin
                bus.ALUSrcA    = 2'b01;
                bus.ALUSrcB    = (state_reg == EXEC_I) ? 2'b01 : 2'b00;
                bus.ALUop      = ALUOP_W'(cmd_dec.aluop);
                bus.FlagUpdate = cmd_dec.valid && (s_bit || is_cmp);
                if (state_reg == EXEC_R)
                    bus.ShiftType = SHIFT_W'({1'b0, bus.INSTRUCTION[6:5]});
            end
            ALU_WB: bus.RegWrite = 1'b1;
            MEM_ADR: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
            end
            MEM_RD: bus.AdrSrc = 1'b1;
            MEM_WB: begin
                bus.RegWrite  = 1'b1;
                bus.ResultSrc = 2'b01;
            end
            MEM_WR: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
                bus.RegSrc   = 2'b10;
            end
            BRANCH, BRANCH_LINK: begin
                bus.PCWrite   = 1'b1;
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                // Link writes PC+4 into R14 in the same cycle the PC is redirected.
                if (state_reg == BRANCH_LINK) begin
                    bus.RegWrite = 1'b1;
                    bus.A3Src    = 1'b1;
                    bus.WD3Src   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.state_out = state_reg;
    assign bus.retired   = retired_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: directed instructions plus randomized ones checked
// against a per-instruction path/output model derived from the ISA rules.
module tb_multicycle_controller;
    import multicycle_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    multicycle_controller_if #(.INSTR_W(32), .ALUOP_W(3), .SHIFT_W(3), .CNT_W(16)) bus ();

    multicycle_controller #(
        .INSTR_W(32), .ALUOP_W(3), .SHIFT_W(3), .SHIFT_NONE(3'b111), .CNT_W(16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

`ifdef BRANCH_LINK_EN
    localparam bit BL_EN = 1'b1;
`else
    localparam bit BL_EN = 1'b0;
`endif

    int     tests_run    = 0;
    int     tests_failed = 0;
    int     exp_retired  = 0;
    state_t exp_path[$];

    logic [21:0] act_ctrl;
    assign act_ctrl = {bus.A3Src, bus.AdrSrc, bus.FlagUpdate, bus.IRWrite, bus.MemWrite,
                       bus.PCWrite, bus.RegWrite, bus.WD3Src, bus.ALUSrcA, bus.ALUSrcB,
                       bus.ResultSrc, bus.RegSrc, bus.ALUop, bus.ShiftType};

    function automatic bit cond_holds(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // {known, aluop} for a data-processing cmd
    function automatic logic [3:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0000: return 4'b1_010;
            4'b0010: return 4'b1_001;
            4'b0100: return 4'b1_000;
            4'b1010: return 4'b1_001;
            4'b1100: return 4'b1_011;
            4'b1101: return 4'b1_100;
            default: return 4'b0_000;
        endcase
    endfunction

    function automatic logic [21:0] exp_ctrl(input state_t st, input logic [31:0] instr);
        logic a3, adr, fu, irw, mw, pcw, rw, wd3;
        logic [1:0] asa, asb, rs, rgs;
        logic [2:0] alu, sh;
        logic [3:0] dec;
        {a3, adr, fu, irw, mw, pcw, rw, wd3} = 8'b0;
        {asa, asb, rs, rgs} = 8'b0;
        alu = 3'b000;
        sh  = 3'b111;
        dec = alu_of(instr[24:21]);
        case (st)
            FETCH:  begin irw = 1; pcw = 1; asb = 2'b11; rs = 2'b10; rgs = 2'b10; end
            DECODE: rgs = 2'b01;
            EXEC_R, EXEC_I: begin
                asa = 2'b01;
                asb = (st == EXEC_I) ? 2'b01 : 2'b00;
                if (st == EXEC_R) sh = {1'b0, instr[6:5]};
                if (dec[3]) begin
                    alu = dec[2:0];
                    fu  = instr[20] || (instr[24:21] == 4'b1010);
                end
            end
            ALU_WB:  rw = 1;
            MEM_ADR: begin asa = 2'b01; asb = 2'b01; end
            MEM_RD:  adr = 1;
            MEM_WB:  begin rw = 1; rs = 2'b01; end
            MEM_WR:  begin adr = 1; mw = 1; rgs = 2'b10; end
            BRANCH:  begin pcw = 1; asa = 2'b01; asb = 2'b01; rs = 2'b10; end
            BRANCH_LINK: begin
                pcw = 1; rw = 1; a3 = 1; wd3 = 1; asa = 2'b01; asb = 2'b01; rs = 2'b10;
            end
            default: ;
        endcase
        return {a3, adr, fu, irw, mw, pcw, rw, wd3, asa, asb, rs, rgs, alu, sh};
    endfunction

    // Expected sequence of states for one instruction starting at FETCH.
    task automatic build_path(input logic [31:0] instr, input logic [3:0] flags, output bit retires);
        logic [3:0] cmd;
        cmd = instr[24:21];
        retires = 1'b0;
        exp_path.delete();
        exp_path.push_back(FETCH);
        exp_path.push_back(DECODE);
        if (!cond_holds(instr[31:28], flags)) return;
        case (instr[27:26])
            2'b00: begin
                exp_path.push_back(instr[25] ? EXEC_I : EXEC_R);
                if (alu_of(cmd) == 4'b0000) return;
                retires = 1'b1;
                if (cmd != 4'b1010) exp_path.push_back(ALU_WB);
            end
            2'b01: begin
                exp_path.push_back(MEM_ADR);
                if (instr[20]) begin
                    exp_path.push_back(MEM_RD);
                    exp_path.push_back(MEM_WB);
                end else begin
                    exp_path.push_back(MEM_WR);
                end
                retires = 1'b1;
            end
            2'b10: begin
                exp_path.push_back((BL_EN && instr[24]) ? BRANCH_LINK : BRANCH);
                retires = 1'b1;
            end
            default: ;
        endcase
    endtask

    // Called at a falling edge with the DUT in FETCH; ends at the next FETCH.
    task automatic run_instr(input logic [31:0] instr, input logic [3:0] flags, input string name);
        bit     ret;
        state_t st;
        bus.INSTRUCTION = instr;
        bus.FLAGS       = flags;
        build_path(instr, flags, ret);
        for (int k = 0; k < exp_path.size(); k++) begin
            st = exp_path[k];
            tests_run++;
            if (bus.state_out !== st) begin
                tests_failed++;
                $display("FAIL %s state step %0d: got %0d expected %0d", name, k, bus.state_out, st);
            end
            tests_run++;
            if (act_ctrl !== exp_ctrl(st, instr)) begin
                tests_failed++;
                $display("FAIL %s ctrl step %0d: got %06h expected %06h", name, k, act_ctrl, exp_ctrl(st, instr));
            end
            @(negedge clock);
        end
        if (ret) exp_retired = (exp_retired + 1) % 65536;
        tests_run++;
        if (bus.retired !== exp_retired[15:0]) begin
            tests_failed++;
            $display("FAIL %s retired: got %0d expected %0d", name, bus.retired, exp_retired);
        end
        $display("[TB] %s instr=%08h flags=%b cycles=%0d retired=%0d", name, instr, flags, exp_path.size(), bus.retired);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.INSTRUCTION = 32'h0;
        bus.FLAGS = 4'h0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exp_retired = 0;
        tests_run++;
        if (bus.state_out !== IDLE || act_ctrl !== exp_ctrl(IDLE, 32'h0) || bus.retired !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset: got state=%0d ctrl=%06h retired=%0d expected state=0 ctrl=%06h retired=0",
                     bus.state_out, act_ctrl, bus.retired, exp_ctrl(IDLE, 32'h0));
        end
        @(negedge clock);
        tests_run++;
        if (bus.state_out !== FETCH) begin
            tests_failed++;
            $display("FAIL reset_to_fetch: got %0d expected %0d", bus.state_out, FETCH);
        end
        $display("[TB] reset done state=%0d", bus.state_out);
    endtask

    task automatic test_mov();    run_instr(32'hE3A0000D, 4'b0000, "mov_imm"); endtask
    task automatic test_branch(); run_instr(32'hEA000002, 4'b0000, "branch"); endtask

    task automatic test_cond_squash();
        run_instr(32'h0A000002, 4'b0000, "beq_not_taken");
        run_instr(32'h0A000002, 4'b0100, "beq_taken");
    endtask

    task automatic test_mem();
        run_instr(32'hE5910004, 4'b0000, "ldr");
        run_instr(32'hE5810004, 4'b0000, "str");
    endtask

    task automatic test_cmp(); run_instr(32'hE1500001, 4'b1010, "cmp_reg"); endtask
    task automatic test_bl();  run_instr(32'hEB000001, 4'b0000, "bl"); endtask

    task automatic test_all_conds();
        logic [3:0] f;
        for (int c = 0; c < 16; c++) begin
            for (int j = 0; j < 4; j++) begin
                f = 4'($urandom);
                run_instr({4'(c), 28'hA000010}, f, "cond_sweep");
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.INSTRUCTION = 32'hE3A0000D;
        bus.FLAGS = 4'b0000;
        repeat (3) @(negedge clock);
        tests_run++;
        if (bus.state_out !== ALU_WB) begin
            tests_failed++;
            $display("FAIL reset_mid reach_wb: got %0d expected %0d", bus.state_out, ALU_WB);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_retired = 0;
        tests_run++;
        if (bus.state_out !== IDLE || bus.RegWrite !== 1'b0 || bus.retired !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_mid: got state=%0d RegWrite=%b retired=%0d expected state=0 RegWrite=0 retired=0",
                     bus.state_out, bus.RegWrite, bus.retired);
        end
        @(negedge clock);
        tests_run++;
        if (bus.state_out !== FETCH) begin
            tests_failed++;
            $display("FAIL reset_mid fetch: got %0d expected %0d", bus.state_out, FETCH);
        end
        $display("[TB] reset_mid done state=%0d retired=%0d", bus.state_out, bus.retired);
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [3:0]  cmds [6];
        cmds[0] = 4'b0000; cmds[1] = 4'b0010; cmds[2] = 4'b0100;
        cmds[3] = 4'b1010; cmds[4] = 4'b1100; cmds[5] = 4'b1101;
        for (int i = 0; i < 200; i++) begin
            r = $urandom;
            if ($urandom_range(1, 0) == 1) r[31:28] = 4'hE;
            if ($urandom_range(3, 0) != 0) r[24:21] = cmds[$urandom_range(5, 0)];
            run_instr(r, 4'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_mov();
        test_branch();
        test_cond_squash();
        test_mem();
        test_cmp();
        test_reset_mid();
        test_bl();
        test_all_conds();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
